// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: datapath width, halt word and FSM encoding.
package fetch_stage_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    localparam logic [WORD_WIDTH-1:0] NOP_WORD = '0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds; sync active-low reset.
module if_id_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_flush,
    input  logic [W-1:0] i_pc,
    input  logic [W-1:0] i_instr,
    output logic         o_valid,
    output logic [W-1:0] o_pc,
    output logic [W-1:0] o_instr
);

    logic         r_valid;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_instr;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, RUN/HALT control, fetched-instruction counter and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned                WORD_WIDTH   = fetch_stage_pkg::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0]      RESET_PC     = '0,
    parameter bit                         HALT_ON_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_instr,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    output logic                  id_valid,
    output logic [WORD_WIDTH-1:0] id_pc,
    output logic [WORD_WIDTH-1:0] id_instr,
    output logic                  halted,
    output logic [WORD_WIDTH-1:0] fetch_count
);

    fetch_state_e            r_state;
    logic [WORD_WIDTH-1:0]   r_pc;
    logic [WORD_WIDTH-1:0]   r_cnt;

    fetch_state_e            w_state_nxt;
    logic [WORD_WIDTH-1:0]   w_pc_nxt;
    logic [WORD_WIDTH-1:0]   w_cnt_nxt;
    logic [WORD_WIDTH-1:0]   w_pc_inc;
    logic                    w_load;
    logic                    w_flush;
    logic                    w_zero_word;
    logic [1:0]              w_unused_bits;

    assign w_pc_inc      = r_pc + WORD_WIDTH'(4);
    assign w_zero_word   = HALT_ON_ZERO && (imem_instr == WORD_WIDTH'(NOP_WORD));
    assign w_unused_bits = branch_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Priority: branch redirect, then freeze, then per-state fetch behaviour.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        if (branch_taken) begin
            w_pc_nxt    = {branch_addr[WORD_WIDTH-1:2], 2'b00};
            w_flush     = 1'b1;
            w_state_nxt = ST_RUN;
        end else if (!freeze) begin
            case (r_state)
                ST_RUN: begin
                    if (w_zero_word) begin
                        w_flush     = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc_inc;
                        if (r_cnt != '1) begin
                            w_cnt_nxt = r_cnt + WORD_WIDTH'(1);
                        end
                    end
                end
                ST_HALT: begin
                    w_flush = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    if_id_reg #(
        .W (WORD_WIDTH)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_pc    (w_pc_inc),
        .i_instr (imem_instr),
        .o_valid (id_valid),
        .o_pc    (id_pc),
        .o_instr (id_instr)
    );

    assign imem_addr   = {2'b00, r_pc[WORD_WIDTH-1:2]};
    assign halted      = (r_state == ST_HALT);
    assign fetch_count = r_cnt;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined ARM-subset core. It owns the program counter, drives the word-indexed instruction memory read port, and consumes the combinational instruction word. It registers the fetched instruction into the IF/ID pipeline register. It handles hazard freeze, branch redirect and halt-on-empty-word, and keeps a fetched-instruction counter.

## Interface
- `WORD_WIDTH`, default 32: datapath width; taken from `settings.h`.
- `RESET_PC`, default 0: byte address loaded into PC at reset; must be 4-aligned.
- `HALT_ON_ZERO`, default 1: when 1, an all-zero fetched word halts fetch.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `imem_addr` out WORD_WIDTH: word index to instruction memory, equal to `{2'b00, pc[31:2]}`; combinational from the PC register.
- `imem_instr` in WORD_WIDTH: instruction word returned combinationally in the same cycle.
- `freeze` in 1: hazard stall from hazard unit.
- `branch_taken` in 1: redirect request from EXE.
- `branch_addr` in WORD_WIDTH: byte target address; bits [1:0] ignored.
- `id_valid` out 1: IF/ID register holds a real instruction.
- `id_pc` out WORD_WIDTH: byte address of the instruction + 4.
- `id_instr` out WORD_WIDTH: registered instruction.
- `halted` out 1: fetch is in HALT.
- `fetch_count` out WORD_WIDTH: instructions delivered to ID; saturating.

## Operation
- The state machine has two states, RUN and HALT. Reset state is RUN.
- Per-edge priority, highest first: reset, `branch_taken`, `freeze`, then normal/halt behaviour.
- Reset (`rst_n`=0 at edge):
  - pc=RESET_PC, state RUN.
  - id_valid=0, id_pc=0, id_instr=0.
  - halted=0, fetch_count=0.
- `branch_taken`=1, in any state:
  - pc ← {branch_addr[31:2],2'b00}.
  - IF/ID ← bubble (id_valid=0, id_instr=0, id_pc=0).
  - State → RUN.
  - This applies even when `freeze`=1 on the same edge.
- `freeze`=1 with no branch: pc, IF/ID, state and fetch_count all hold.
- RUN, normal cycle, `imem_instr`≠0 or HALT_ON_ZERO=0:
  - IF/ID ← {pc+4, imem_instr}, id_valid=1.
  - pc ← pc+4, with modulo-2^32 wrap.
  - fetch_count increments, saturating at all-ones.
- RUN, `imem_instr`=0 and HALT_ON_ZERO=1:
  - IF/ID ← bubble, pc holds.
  - State → HALT, fetch_count unchanged.
- HALT, no branch:
  - pc holds and IF/ID ← bubble every cycle.
  - Only `branch_taken` or reset leaves HALT.
- `halted` equals (state==HALT), registered.

## Timing
- imem read is zero-latency: the address is visible combinationally from pc, and the instruction is sampled on the same edge.
- Fetch-to-ID latency is 1 cycle. Throughput is 1 instruction/cycle in RUN without freeze.
- Branch penalty: the edge with `branch_taken` inserts one bubble. The target instruction appears in IF/ID on the following edge.
- HALT entry: `halted`=1 and id_valid=0 from the edge that samples the zero word.
- HALT exit: `halted`=0 on the branch edge. The first valid target instruction arrives one edge later.
- Freeze across a halt-triggering zero word: no transition until freeze drops.
- Reset asserted mid-operation overrides branch/freeze on that edge. Outputs take reset values at that edge.
- PC wrap: pc=0xFFFF_FFFC → next pc=0, id_pc=0.

## Structure
- Shared package/header (`settings.h`) holds:
  - `WORD_WIDTH`.
  - The NOP/halt word constant (32'h0).
  - The fetch state encoding (RUN=1'b0, HALT=1'b1).
- One sub-module, `if_id_reg`: the IF/ID pipeline register with load, flush and hold controls and synchronous active-low reset.
- `fetch_stage` keeps the PC, the state machine and the counter.

## Test plan
- Reset release, memory returns nonzero words for indices 0..3, no freeze:
  - imem_addr steps 0,1,2,3.
  - id_pc steps 4,8,12,16, one cycle behind.
  - id_valid=1 from the second edge; fetch_count=4 after 4 deliveries.
- Freeze held 3 cycles at pc=8:
  - imem_addr stays 2, IF/ID holds the instruction at pc=4, fetch_count is constant.
  - Release resumes with id_pc=12.
- branch_taken with branch_addr=0x3C, with freeze also high on that edge:
  - Next cycle imem_addr=15 and id_valid=0.
  - The following cycle id_pc=0x40 and id_valid=1.
- Memory returns 0 at index 18:
  - halted=1, id_valid=0, imem_addr stays 18 for 10 cycles, fetch_count frozen.
  - branch_addr=0 with branch_taken then gives halted=0, and id_pc=4 one cycle later.
- HALT_ON_ZERO=0 with a zero word: it is delivered with id_valid=1, halted stays 0.
- Reset asserted during HALT and during a branch edge: pc=RESET_PC, all outputs take their reset values on that edge.
